dpram_sync_fifo: RTL
====================

# dpram_sync_fifo

Parametrised single-clock FIFO built on one `DPRAM_36K_BLK` true-dual-port 36 Kbit block RAM, for the qlf_k6n10f flow. It supports the 9/18/36-bit aspect ratios with depth derived from width. It adds pointer/count management, full/empty and programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Port 1 of the RAM is the write side and port 2 is the read side; both run on the same clock.

## Interface
Parameters:
- `DATA_WIDTH`, 36: word width. Legal values are 9, 18 or 36; any other value is an elaboration error.
- `ADDR_WIDTH`, derived: 10 / 11 / 12 for widths 36 / 18 / 9. Not user-overridable.
- `DEPTH`, derived: `2**ADDR_WIDTH`, which gives 1024 / 2048 / 4096.
- `AF_LEVEL`, `DEPTH-4`: `ALMOST_FULL_o` is asserted when count ≥ `AF_LEVEL`. Legal range is 1..DEPTH.
- `AE_LEVEL`, 4: `ALMOST_EMPTY_o` is asserted when count ≤ `AE_LEVEL`. Legal range is 0..DEPTH-1.

Ports:
- `CLK_i`  in  1  the single clock, driving both RAM ports.
- `RST_i`  in  1  synchronous, active-high reset.
- `PUSH_i`  in  1  write request.
- `WDATA_i`  in  DATA_WIDTH  write data.
- `POP_i`  in  1  read request.
- `RDATA_o`  out  DATA_WIDTH  read data; meaningful only while `RVALID_o` = 1.
- `RVALID_o`  out  1  `RDATA_o` holds the word from the pop accepted in the previous cycle.
- `FULL_o`  out  1  count == DEPTH.
- `EMPTY_o`  out  1  count == 0.
- `ALMOST_FULL_o`  out  1  count ≥ AF_LEVEL.
- `ALMOST_EMPTY_o`  out  1  count ≤ AE_LEVEL.
- `COUNT_o`  out  ADDR_WIDTH+1  number of stored words.
- `OVERFLOW_o`  out  1  sticky flag: a push was rejected. Cleared only by reset.
- `UNDERFLOW_o`  out  1  sticky flag: a pop was rejected. Cleared only by reset.

## Operation
- Internal state:
  - `wr_ptr` and `rd_ptr`, each ADDR_WIDTH bits, wrapping modulo DEPTH with no special handling at the wrap.
  - `count`, ADDR_WIDTH+1 bits.
- Acceptance rules, evaluated on current registered flags:
  - A push is accepted iff `PUSH_i && !FULL_o`.
  - A pop is accepted iff `POP_i && !EMPTY_o`.
- Accepted push:
  - RAM port 1 writes `WDATA_i` at `wr_ptr`, with `WEN1_i`=1 and `WR1_BE_i` all ones.
  - `wr_ptr` increments.
- Accepted pop:
  - RAM port 2 reads `rd_ptr` with `REN2_i`=1.
  - `rd_ptr` increments.
  - `RVALID_o` is 1 on the next cycle.
- RAM port tie-offs:
  - Port 1 read enable is tied off (0).
  - Port 2 write enable is tied off (0).
- Count update: `count` changes by +1 for push-only, −1 for pop-only, and 0 when both are accepted.
- Simultaneous events:
  - Empty + push + pop: push accepted; pop rejected and `UNDERFLOW_o` set.
  - Full + push + pop: pop accepted; push rejected and `OVERFLOW_o` set. This avoids same-address read/write collision.
  - Otherwise both are accepted. Read and write addresses then differ by construction.
- Flag registers:
  - All flags are registers computed from next-count, so they are consistent with `COUNT_o` every cycle.
  - No combinational path from `PUSH_i`/`POP_i` to any flag.
- Reset (`RST_i`=1 at a clock edge):
  - Pointers, count, `RVALID_o`, `OVERFLOW_o` and `UNDERFLOW_o` go to 0.
  - `EMPTY_o`=1, `FULL_o`=0.
  - `ALMOST_EMPTY_o`=1.
  - `ALMOST_FULL_o`=0.
  - RAM contents are not cleared.
- Reset mid-operation:
  - A pop accepted in the cycle before reset does not produce `RVALID_o` after reset.
  - Push/pop in the reset cycle are ignored.
- `RDATA_o` is the raw RAM output and has no reset value.

## Timing
- Push at edge n:
  - `EMPTY_o`/`COUNT_o` update after edge n.
  - The word can be popped in cycle n+1.
- Pop accepted at edge n: `RDATA_o` valid with `RVALID_o`=1 in cycle n+1; `RVALID_o` drops at edge n+1 if no further pop.
- Read latency: 1 cycle, fixed.
- Throughput: one push and one pop per cycle, sustained.
- Back-to-back pops give continuous `RVALID_o`, with data in FIFO order.
- `RDATA_o` holds its last value when not popping; a RAM with `REN2_i`=0 holds its output.

## Structure
- Shared package/header `ql_bram_pkg`:
  - the width→ADDR_WIDTH function;
  - the legal-width check;
  - the `BRAM36K_BITS` = 36864 constant, shared with future 18K/36K RAM wrappers.
- One sub-module `dpram_fifo_ctrl` holds pointers, count, flags and error logic, and is unit-testable without the RAM.
- The top instantiates `dpram_fifo_ctrl` plus one `DPRAM_36K_BLK`, with BE widths 4 / 2 / 1 for data widths 36 / 18 / 9.

## Test plan
- **Reset, push/pop order (DATA_WIDTH=36):**
  - Stimulus: reset, then push 0x1, 0x2, 0x3, then pop ×3 back-to-back.
  - Response: `RVALID_o` high for 3 consecutive cycles, each starting one cycle after its pop, with `RDATA_o` = 0x1, 0x2, 0x3.
  - `COUNT_o` goes 1, 2, 3, 2, 1, 0 and `EMPTY_o` re-asserts.
- **Fill (DATA_WIDTH=9):**
  - Stimulus: push 4096 words (value = index mod 512).
  - Response: `ALMOST_FULL_o` rises when `COUNT_o` = 4092; `FULL_o` rises at 4096.
  - A 4097th push is rejected: `OVERFLOW_o`=1 and count stays 4096.
  - Draining returns 0..511 repeating, proving pointer wrap.
- **Underflow:**
  - Stimulus: pop on an empty FIFO.
  - Response: `UNDERFLOW_o`=1, `RVALID_o` stays 0, count stays 0.
  - `UNDERFLOW_o` stays 1 until `RST_i`.
- **Simultaneous push/pop (DATA_WIDTH=18):**
  - When empty: only the push is accepted, count goes to 1, `UNDERFLOW_o` is set.
  - When full (2048): only the pop is accepted, count goes to 2047, `OVERFLOW_o` is set.
  - At count 100: both accepted, count stays 100, data order preserved.
- **Reset mid-operation:**
  - Stimulus: with count = 10, pop at edge n and assert `RST_i` at edge n+1.
  - Response: `RVALID_o`=0 after the reset edge; `EMPTY_o`=1, `COUNT_o`=0; both sticky flags are 0.
  - A fresh push of 0xAB then pop returns 0xAB.
- **Random soak:**
  - Stimulus: 100k cycles of random push/pop against a scoreboard queue model, for all three widths.
  - Response: zero mismatches.
  - Flags match the model count every cycle.

Source files
------------

// File: rtl/ql_bram_pkg.sv
// Shared helpers for wrappers around the qlf_k6n10f 36 Kbit block RAM.
package ql_bram_pkg;

  localparam int unsigned BRAM36K_BITS = 36864;
  localparam int unsigned BRAM_LANE_BITS = 9;

  function automatic bit bram_width_legal(input int unsigned w);
    return (w == 9) || (w == 18) || (w == 36);
  endfunction

  // Depth is whatever fills the whole block at the chosen aspect ratio.
  function automatic int unsigned bram_addr_width(input int unsigned w);
    case (w)
      36:      return 10;
      18:      return 11;
      9:       return 12;
      default: return 10;
    endcase
  endfunction

  // One byte-enable per 9-bit lane.
  function automatic int unsigned bram_be_width(input int unsigned w);
    return (w + BRAM_LANE_BITS - 1) / BRAM_LANE_BITS;
  endfunction

endpackage

// File: rtl/dpram_36k_blk.sv
// Behavioural stand-in for the DPRAM_36K_BLK true-dual-port block RAM,
// restricted to both ports sharing one clock (CLK1_i).
module DPRAM_36K_BLK #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BE_WIDTH   = 4
) (
  input  logic                  CLK1_i,
  input  logic                  WEN1_i,
  input  logic [BE_WIDTH-1:0]   WR1_BE_i,
  input  logic                  REN1_i,
  input  logic [ADDR_WIDTH-1:0] ADDR1_i,
  input  logic [DATA_WIDTH-1:0] WDATA1_i,
  output logic [DATA_WIDTH-1:0] RDATA1_o,
  input  logic                  CLK2_i,
  input  logic                  WEN2_i,
  input  logic [BE_WIDTH-1:0]   WR2_BE_i,
  input  logic                  REN2_i,
  input  logic [ADDR_WIDTH-1:0] ADDR2_i,
  input  logic [DATA_WIDTH-1:0] WDATA2_i,
  output logic [DATA_WIDTH-1:0] RDATA2_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LANE  = DATA_WIDTH / BE_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata1_q, rdata2_q;
  logic                  clk2_unused;

  assign clk2_unused = CLK2_i;

  // Lane-masked writes, read-before-write registered reads that hold when idle.
  always_ff @(posedge CLK1_i) begin
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (WEN1_i && WR1_BE_i[b]) mem_q[ADDR1_i][b*LANE +: LANE] <= WDATA1_i[b*LANE +: LANE];
      if (WEN2_i && WR2_BE_i[b]) mem_q[ADDR2_i][b*LANE +: LANE] <= WDATA2_i[b*LANE +: LANE];
    end
    if (REN1_i) rdata1_q <= mem_q[ADDR1_i];
    if (REN2_i) rdata2_q <= mem_q[ADDR2_i];
  end

  assign RDATA1_o = rdata1_q;
  assign RDATA2_o = rdata2_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Pointer, count, flag and sticky-error management for the block-RAM FIFO.
module dpram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned AF_LEVEL   = 1020,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_AE    = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic rvalid_q, rvalid_d, full_q, full_d, empty_q, empty_d;
  logic af_q, af_d, ae_q, ae_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic push_ok, pop_ok;

  // Acceptance uses only registered flags; nothing is accepted during reset.
  assign push_ok = push_i && !full_q && !rst_i;
  assign pop_ok  = pop_i && !empty_q && !rst_i;

  // Next-state: pointers, count, and flags derived from the next count.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d      = (count_d == CNT_DEPTH);
    empty_d     = (count_d == '0);
    af_d        = (count_d >= CNT_AF);
    ae_d        = (count_d <= CNT_AE);
    overflow_d  = overflow_q  | (push_i & full_q);
    underflow_d = underflow_q | (pop_i & empty_q);
    rvalid_d    = pop_ok;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rvalid_q    <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rvalid_q    <= rvalid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_en_o        = push_ok;
  assign wr_addr_o      = wr_ptr_q;
  assign rd_en_o        = pop_ok;
  assign rd_addr_o      = rd_ptr_q;
  assign rvalid_o       = rvalid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/dpram_sync_fifo.sv
// Single-clock FIFO on one 36 Kbit block RAM: port 1 writes, port 2 reads.
module dpram_sync_fifo import ql_bram_pkg::*; #(
  parameter  int unsigned DATA_WIDTH = 36,
  localparam int unsigned ADDR_WIDTH = bram_addr_width(DATA_WIDTH),
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH,
  parameter  int unsigned AF_LEVEL   = DEPTH - 4,
  parameter  int unsigned AE_LEVEL   = 4
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  PUSH_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  POP_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  output logic                  FULL_o,
  output logic                  EMPTY_o,
  output logic                  ALMOST_FULL_o,
  output logic                  ALMOST_EMPTY_o,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o
);

  localparam int unsigned BE_WIDTH = bram_be_width(DATA_WIDTH);

  if (!bram_width_legal(DATA_WIDTH)) begin : g_bad_width
    $error("dpram_sync_fifo: DATA_WIDTH must be 9, 18 or 36");
  end
  if (DEPTH * DATA_WIDTH > BRAM36K_BITS) begin : g_bad_size
    $error("dpram_sync_fifo: geometry exceeds one 36K block");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("dpram_sync_fifo: AF_LEVEL out of range");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("dpram_sync_fifo: AE_LEVEL out of range");
  end

  logic                  wr_en, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rdata1_unused;

  dpram_fifo_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .AF_LEVEL  (AF_LEVEL),
    .AE_LEVEL  (AE_LEVEL)
  ) u_ctrl (
    .clk_i         (CLK_i),
    .rst_i         (RST_i),
    .push_i        (PUSH_i),
    .pop_i         (POP_i),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .rvalid_o      (RVALID_o),
    .full_o        (FULL_o),
    .empty_o       (EMPTY_o),
    .almost_full_o (ALMOST_FULL_o),
    .almost_empty_o(ALMOST_EMPTY_o),
    .count_o       (COUNT_o),
    .overflow_o    (OVERFLOW_o),
    .underflow_o   (UNDERFLOW_o)
  );

  DPRAM_36K_BLK #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BE_WIDTH  (BE_WIDTH)
  ) u_ram (
    .CLK1_i  (CLK_i),
    .WEN1_i  (wr_en),
    .WR1_BE_i('1),
    .REN1_i  (1'b0),
    .ADDR1_i (wr_addr),
    .WDATA1_i(WDATA_i),
    .RDATA1_o(rdata1_unused),
    .CLK2_i  (CLK_i),
    .WEN2_i  (1'b0),
    .WR2_BE_i('0),
    .REN2_i  (rd_en),
    .ADDR2_i (rd_addr),
    .WDATA2_i('0),
    .RDATA2_o(RDATA_o)
  );

endmodule
